seq_multiplier: RTL
===================

# seq_multiplier

Parametrised sequential shift-add multiplier for the ALU datapath: the next generation of the 32-bit unsigned iterative multiplier. It supports WIDTH-bit operands, both signed (MULT) and unsigned (MULTU) operation, and an explicit start/busy/done handshake. The full 2·WIDTH-bit product is held in a result register until the next accepted operation. It sits beside the ALU, is dispatched by the same 6-bit function code, and feeds the HI/LO registers.

## Interface
- WIDTH, 32: operand width in bits; legal range 4..64.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled on the rising edge of clk.
- Signal  in  6  function code; 6'd24 = MULT (signed), 6'd25 = MULTU (unsigned).
- inputA  in  WIDTH  multiplicand.
- inputB  in  WIDTH  multiplier.
- result  out  2·WIDTH  product register.
- busy  out  1  high while an operation is in flight.
- done  out  1  single-cycle pulse when result updates.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: iterating.
  - FIN: correction and writeback.
- IDLE → RUN: start=1 and Signal ∈ {24, 25}.
  - inputA/inputB are latched; the MULT/MULTU mode is latched; the iteration counter is cleared.
  - Any other Signal value with start=1 is ignored and the block stays in IDLE.
- Signed mode:
  - Operands are converted to magnitudes. -2^(WIDTH-1) maps to the unsigned value 2^(WIDTH-1).
  - neg = signA XOR signB is latched.
  - In FIN the product is two's-complement negated if neg=1.
- RUN iteration, one per cycle:
  - If MLER[0]=1, then acc += MCAND.
  - MCAND <<= 1 (2·WIDTH bits), MLER >>= 1, count += 1.
  - After WIDTH iterations, go to FIN.
- Arithmetic:
  - The accumulator is 2·WIDTH bits wide; overflow is impossible.
  - In signed mode the result is the exact signed 2·WIDTH-bit product, including (-2^(WIDTH-1))² = 2^(2·WIDTH-2).
- FIN: result ← corrected acc; done=1 for one cycle; next state is IDLE.
- result holds its value from FIN until the next FIN or reset. It does not change during RUN.
- start while busy=1 is ignored: no queuing and no operand corruption.
- Operand and Signal changes after acceptance have no effect.

## Timing
- Acceptance edge E0 (start=1 in IDLE): busy=1 from E0.
- Without early termination:
  - Edges E1..E_WIDTH perform the iterations.
  - Edge E_(WIDTH+1) is FIN: result is valid and done=1 after it, and busy=0 after it.
  - Latency is WIDTH+1 cycles from acceptance to result.
- done deasserts at the next edge.
- A new start is accepted on the edge immediately after FIN; back-to-back throughput is one result per WIDTH+2 cycles.
- reset=1 at any edge, including mid-RUN or in FIN:
  - State goes to IDLE; result=0, busy=0, done=0; internal registers are cleared.
  - No done pulse is produced for the aborted operation.
- Reset values: result=0, busy=0, done=0.

## Configuration
- MULT_EARLY_TERM_EN defined:
  - In RUN, if the remaining MLER is zero at an edge, that edge performs FIN instead of an iteration.
  - Latency = 1 + (index of the highest set bit of |inputB| + 1); a zero multiplier gives latency 1.
  - done/busy semantics are unchanged.
- MULT_EARLY_TERM_EN undefined:
  - Fixed latency of WIDTH+1 regardless of operand value.
- The product value is identical in both builds.

## Structure
- Shared package mult_pkg:
  - Function-code constants MULT=6'd24 and MULTU=6'd25, shared with the ALU decoder.
  - The state enum {IDLE, RUN, FIN}.
- The counter width is derived in-module as $clog2(WIDTH+1).
- No sub-module: magnitude conversion and negation are inline expressions; a separate datapath module is not warranted at this size.

## Test plan
- WIDTH=32, MULTU, inputA=3, inputB=5 → result=64'd15; done exactly 33 cycles after the acceptance edge; busy high for 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE00000001. Same operands with MULT (-1 × -1) → 64'd1.
- MULT -3 × 7 → 0xFFFFFFFFFFFFFFEB. MULT 0x80000000 × 0x80000000 → 0x4000000000000000.
- Sequence: operation 15 completes, then a new start is issued; reset asserted mid-RUN at cycle 10 → result=0, busy=0, done=0 next cycle, and no done pulse. A new MULTU 2×2 afterwards → 4.
- Behaviour while busy:
  - A start with different operands while busy=1 is ignored; the original product is returned.
  - start with Signal=6'd32 in IDLE → busy stays 0.
- With MULT_EARLY_TERM_EN: MULTU 7×1 → 7, latency 2. 7×0 → 0, latency 1. 7×0x80000000 → latency 33.

Source files
------------

// File: rtl/mult_pkg.sv
// Definitions shared by the sequential multiplier and the ALU decoder.
// Contains the MULT/MULTU function codes and the multiplier FSM state encoding.
package mult_pkg;

  localparam logic [5:0] MULT  = 6'd24;
  localparam logic [5:0] MULTU = 6'd25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mult_state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier (signed MULT / unsigned MULTU) with a start/busy/done handshake.
// Optional build macro MULT_EARLY_TERM_EN ends the iteration once the remaining multiplier is zero.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [5:0]           Signal,
  input  logic [WIDTH-1:0]     inputA,
  input  logic [WIDTH-1:0]     inputB,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]      COUNT_LAST = CW'(WIDTH);
  localparam logic [CW-1:0]      ONE_C      = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ONE_W      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_P      = {{(2*WIDTH-1){1'b0}}, 1'b1};

`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  mult_state_e        state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mler_q, mler_d;
  logic [CW-1:0]      count_q, count_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept_s;
  logic               is_signed_s;
  logic               fin_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;

  // In signed mode the most negative operand maps to 2^(WIDTH-1), which still fits WIDTH unsigned bits.
  assign is_signed_s = (Signal == MULT);
  assign accept_s    = start && ((Signal == MULT) || (Signal == MULTU));
  assign mag_a_s     = (is_signed_s && inputA[WIDTH-1]) ? (~inputA + ONE_W) : inputA;
  assign mag_b_s     = (is_signed_s && inputB[WIDTH-1]) ? (~inputB + ONE_W) : inputB;

  // Next-state and datapath update for the IDLE/RUN/FIN sequence.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mler_d   = mler_q;
    count_d  = count_q;
    neg_d    = neg_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    fin_s    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = RUN;
          busy_d  = 1'b1;
          acc_d   = '0;
          count_d = '0;
          mcand_d = {{WIDTH{1'b0}}, mag_a_s};
          mler_d  = mag_b_s;
          neg_d   = is_signed_s && (inputA[WIDTH-1] ^ inputB[WIDTH-1]);
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (EARLY_TERM && (mler_q == '0)) begin
          fin_s = 1'b1;
        end else begin
          if (mler_q[0]) begin
            acc_d = acc_q + mcand_q;
          end else begin
            acc_d = acc_q;
          end
          mcand_d = mcand_q << 1;
          mler_d  = mler_q >> 1;
          count_d = count_q + ONE_C;
          if ((count_q + ONE_C) == COUNT_LAST) begin
            state_d = FIN;
          end else begin
            state_d = RUN;
          end
        end
      end
      FIN: begin
        fin_s = 1'b1;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Writeback applies the sign correction; the accumulator is wide enough that no overflow occurs.
    if (fin_s) begin
      state_d  = IDLE;
      result_d = neg_q ? (~acc_q + ONE_P) : acc_q;
      busy_d   = 1'b0;
      done_d   = 1'b1;
    end else begin
      done_d   = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mler_q   <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mler_q   <= mler_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
